pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives enable/flush of if_id_reg,
//  id_ex_reg, ex_mem_reg, mem_wb_reg and the PC register.
//  Resolves load-use hazards, taken-branch redirects, instruction/data memory wait states,
//  and an ebreak-style halt with pipeline drain.
//  Sits in the core top beside the hazard/forwarding logic; purely control, no datapath.
// PARAMETERS
//  DRAIN_CYC  3   cycles to drain ID..WB after a halt request before freezing
//  CNT_W      32  width of performance counters (used only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk          in   1   core clock
//  rst          in   1   asynchronous reset, active-high
//  id_rs1/rs2   in   5   r_t source regs of instruction in ID
//  id_use_rs1/2 in   1   ID instruction actually reads rs1/rs2
//  ex_rd        in   5   r_t destination of instruction in EX
//  ex_is_load   in   1   EX instruction is a load
//  br_taken     in   1   EX resolved taken branch/jump (single-cycle pulse per branch)
//  imem_busy    in   1   fetch not ready this cycle
//  dmem_busy    in   1   data memory access in MEM not complete
//  halt_req     in   1   ID holds ebreak/halt instruction
//  resume       in   1   leave HALT (pulse)
//  pc_en        out  1   PC register update enable
//  if_id_en/_flush, id_ex_en/_flush, ex_mem_en, mem_wb_en  out 1 each  stage register controls
//  halted       out  1   pipeline frozen in HALT
//  stall_cnt, flush_cnt  out CNT_W  perf counters (only with PIPE_CTRL_PERF_EN)
// BEHAVIOUR
//  - Outputs are combinational from state and inputs; state/counters in flops, async clear on rst.
//  - States: INIT, RUN, LU_STALL, DWAIT, DRAIN, HALT. Reset -> INIT.
//  - INIT (1 cycle after rst deasserts): pc_en=0, all *_en=1, if_id_flush=id_ex_flush=1,
//    halted=0 -> RUN. While rst is high, outputs are held at these INIT values.
//  - Load-use hazard: ex_is_load && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) ||
//    (id_use_rs2 && id_rs2==ex_rd)).
//  - Priority in RUN, highest first: dmem_busy > br_taken > load-use > halt_req > imem_busy.
//  - dmem_busy: every *_en=0 and pc_en=0, no flushes; go to DWAIT. DWAIT holds until
//    dmem_busy=0, then returns to RUN. A br_taken seen during DWAIT is not acted on
//    until RUN; EX is frozen, so br_taken stays asserted.
//  - br_taken: pc_en=1 (target loaded); if_id_flush=id_ex_flush=1 (2 bubbles); others advance.
//    A branch overrides a same-cycle load-use hazard and halt_req (the wrong-path instruction is killed).
//  - load-use: pc_en=0, if_id_en=0, id_ex_flush=1, EX/MEM/WB advance. Go to LU_STALL for
//    exactly one cycle, then RUN, with normal outputs in LU_STALL unless another event fires.
//  - imem_busy (RUN): pc_en=0, if_id_flush=1 (bubble), rest advance; remains in RUN.
//  - halt_req: pc_en=0, if_id_flush=1, load drain counter=DRAIN_CYC-1, go to DRAIN. In DRAIN,
//    if_id_flush=1, pc_en=0, others advance, and the counter decrements. dmem_busy freezes DRAIN
//    and the counter does not decrement. At 0 -> HALT.
//  - HALT: every *_en=0, pc_en=0, halted=1. resume -> INIT (refetch from held PC).
//  - Flush wins over en on the same register (flush loads NOP/zeros).
//  - Reset mid-operation from any state -> INIT immediately; counters are cleared.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//    stall_cnt +1 per cycle with pc_en=0 outside HALT/INIT.
//    flush_cnt +1 per br_taken acted on.
//    Both counters saturate at all-ones and clear on rst.
//  Not defined: stall_cnt/flush_cnt ports are absent; no counter flops.
// STRUCTURE
//  Shared package (opcode.svh): pipe_state_t enum, R_ZERO constant, r_t/data_t reuse.
//  Sub-module: lu_hazard_detect (combinational load-use compare) instantiated once.
// TESTING
//  1. Reset then release: cycle 0 INIT flush=1, pc_en=0; cycle 1 RUN all en=1, pc_en=1.
//  2. Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_en=0,
//     if_id_en=0, id_ex_flush=1, then normal.
//  3. ex_rd=0 with load and id_rs2=0 -> no stall; br_taken plus load-use in the same
//     cycle -> pc_en=1, both flushes, no stall.
//  4. dmem_busy high 4 cycles with br_taken=1 -> 4 frozen cycles (all en=0), then
//     branch flush in cycle 5.
//  5. halt_req -> 3 DRAIN cycles (if_id_flush=1), then halted=1. resume -> INIT -> RUN.
//     With PIPE_CTRL_PERF_EN, stall_cnt counts 4.
//  6. Assert rst during DRAIN -> outputs are the INIT values asynchronously;
//     after release, the state is RUN within 1 cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: register index type,
// the x0 constant and the sequencer state encoding.
package pipe_ctrl_pkg;

  typedef logic [4:0]  r_t;
  typedef logic [31:0] data_t;

  localparam r_t R_ZERO = 5'd0;

  typedef enum logic [2:0] {
    INIT,
    RUN,
    LU_STALL,
    DWAIT,
    DRAIN,
    HALT
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_lu_hazard_detect.sv
// Combinational load-use detector: the instruction in ID reads a register
// that a load currently in EX has not produced yet.
module lu_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  r_t   id_rs1,
  input  r_t   id_rs2,
  input  logic id_use_rs1,
  input  logic id_use_rs2,
  input  r_t   ex_rd,
  input  logic ex_is_load,
  output logic hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard  = ex_is_load && (ex_rd != R_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYC = 3
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  input  r_t   id_rs1,
  input  r_t   id_rs2,
  input  logic id_use_rs1,
  input  logic id_use_rs2,
  input  r_t   ex_rd,
  input  logic ex_is_load,
  input  logic br_taken,
  input  logic imem_busy,
  input  logic dmem_busy,
  input  logic halt_req,
  input  logic resume,
  output logic pc_en,
  output logic if_id_en,
  output logic if_id_flush,
  output logic id_ex_en,
  output logic id_ex_flush,
  output logic ex_mem_en,
  output logic mem_wb_en,
  output logic halted
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

  pipe_state_t   state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          lu_hazard;

  lu_hazard_detect u_lu_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .hazard     (lu_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    halted      = 1'b0;
    case (state)
      INIT: begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nxt   = RUN;
      end
      // LU_STALL and a released DWAIT behave exactly like RUN for new events
      RUN, LU_STALL, DWAIT: begin
        state_nxt = RUN;
        if (dmem_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
          state_nxt = DWAIT;
        end else if (br_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu_hazard) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          state_nxt   = LU_STALL;
        end else if (halt_req) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          drain_nxt   = DW'(DRAIN_CYC - 1);
          state_nxt   = DRAIN;
        end else if (imem_busy) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_en = 1'b0;
        if (dmem_busy) begin
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else begin
          if_id_flush = 1'b1;
          if (drain_cnt == '0) state_nxt = HALT;
          else drain_nxt = drain_cnt - DW'(1);
        end
      end
      HALT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        halted    = 1'b1;
        if (resume) state_nxt = INIT;
      end
      default: state_nxt = INIT;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_ev;
  logic br_act;

  assign stall_ev = !pc_en && (state != HALT) && (state != INIT);
  assign br_act   = ((state == RUN) || (state == LU_STALL) || (state == DWAIT))
                    && !dmem_busy && br_taken;

  // Saturating counters; they stick at all-ones rather than wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_act && (flush_cnt != '1))   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  // Default build carries no counter state.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  r_t   id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0;
  logic br_taken = 0, imem_busy = 0, dmem_busy = 0, halt_req = 0, resume = 0;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .br_taken(br_taken),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .halted(halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Output vector {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted}
  localparam logic [7:0] V_INIT  = 8'b0111_1110;
  localparam logic [7:0] V_ADV   = 8'b1101_0110;
  localparam logic [7:0] V_FRZ   = 8'b0000_0000;
  localparam logic [7:0] V_BR    = 8'b1111_1110;
  localparam logic [7:0] V_LU    = 8'b0001_1110;
  localparam logic [7:0] V_BUB   = 8'b0111_0110;
  localparam logic [7:0] V_HALT  = 8'b0000_0001;

  logic [7:0] dut_v;
  assign dut_v = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, halted};

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Model: remaining-drain count, halted flag and "first cycle after reset/resume" flag
  bit          m_init  = 1'b1;
  bit          m_halt  = 1'b0;
  int          m_drain = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;
  logic [7:0]  m_exp;
  bit          m_hz;

  always @(negedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_halt = 1'b0; m_drain = 0; m_stall = 0; m_flush = 0;
      check_output("reset_outputs", {24'd0, dut_v}, {24'd0, V_INIT});
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      check_output("stall_cnt", stall_cnt, m_stall);
      check_output("flush_cnt", flush_cnt, m_flush);
`endif
      m_hz = ex_is_load && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (m_init) begin
        m_exp  = V_INIT;
        m_init = 1'b0;
      end else if (m_halt) begin
        m_exp = V_HALT;
        if (resume) begin m_halt = 1'b0; m_init = 1'b1; end
      end else if (m_drain > 0) begin
        if (dmem_busy) m_exp = V_FRZ;
        else begin
          m_exp = V_BUB;
          m_drain--;
          if (m_drain == 0) m_halt = 1'b1;
        end
        m_stall++;
      end else begin
        if (dmem_busy)      m_exp = V_FRZ;
        else if (br_taken)  begin m_exp = V_BR; m_flush++; end
        else if (m_hz)      m_exp = V_LU;
        else if (halt_req)  begin m_exp = V_BUB; m_drain = 3; end
        else if (imem_busy) m_exp = V_BUB;
        else                m_exp = V_ADV;
        if (!m_exp[7]) m_stall++;
      end
      check_output("model_outputs", {24'd0, dut_v}, {24'd0, m_exp});
    end
  end

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    br_taken = 0; imem_busy = 0; dmem_busy = 0; halt_req = 0; resume = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic apply_stimulus();
    id_rs1     = r_t'($urandom_range(0, 3));
    id_rs2     = r_t'($urandom_range(0, 3));
    ex_rd      = r_t'($urandom_range(0, 3));
    id_use_rs1 = $urandom_range(0, 1);
    id_use_rs2 = $urandom_range(0, 1);
    ex_is_load = ($urandom_range(0, 2) == 0);
    br_taken   = ($urandom_range(0, 9) == 0);
    imem_busy  = ($urandom_range(0, 4) == 0);
    dmem_busy  = ($urandom_range(0, 6) == 0);
    halt_req   = ($urandom_range(0, 14) == 0);
    resume     = ($urandom_range(0, 4) == 0);
    rst        = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    #2 check_output("rst_held", {24'd0, dut_v}, {24'd0, V_INIT});
    @(posedge clk); #1 rst = 0;
    #2 check_output("init_cycle", {24'd0, dut_v}, {24'd0, V_INIT});
    next_cycle(); #2 check_output("first_run", {24'd0, dut_v}, {24'd0, V_ADV});

    // Load-use on rs1 stalls exactly one cycle
    next_cycle(); ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
    #2 check_output("lu_stall", {24'd0, dut_v}, {24'd0, V_LU});
    next_cycle(); #2 check_output("lu_after", {24'd0, dut_v}, {24'd0, V_ADV});

    // x0 destination never stalls; branch beats same-cycle load-use
    next_cycle(); ex_is_load = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1;
    #2 check_output("lu_x0", {24'd0, dut_v}, {24'd0, V_ADV});
    next_cycle(); ex_is_load = 1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1; br_taken = 1;
    #2 check_output("br_over_lu", {24'd0, dut_v}, {24'd0, V_BR});

    // Data wait freezes everything, pending branch acts on release
    for (int i = 0; i < 4; i++) begin
      next_cycle(); dmem_busy = 1; br_taken = 1;
      #2 check_output("dwait_freeze", {24'd0, dut_v}, {24'd0, V_FRZ});
    end
    next_cycle(); br_taken = 1;
    #2 check_output("dwait_branch", {24'd0, dut_v}, {24'd0, V_BR});
    next_cycle(); #2 check_output("post_branch", {24'd0, dut_v}, {24'd0, V_ADV});

    // Halt: request cycle, three drain cycles, then frozen
    next_cycle(); halt_req = 1;
    #2 check_output("halt_req", {24'd0, dut_v}, {24'd0, V_BUB});
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #2 check_output("drain", {24'd0, dut_v}, {24'd0, V_BUB});
    end
    next_cycle(); #2 check_output("halted", {24'd0, dut_v}, {24'd0, V_HALT});
`ifdef PIPE_CTRL_PERF_EN
    check_output("stall_cnt_lit", stall_cnt, 32'd9);
    check_output("flush_cnt_lit", flush_cnt, 32'd2);
`endif
    next_cycle(); #2 check_output("halt_hold", {24'd0, dut_v}, {24'd0, V_HALT});
    next_cycle(); resume = 1;
    #2 check_output("halt_resume", {24'd0, dut_v}, {24'd0, V_HALT});
    next_cycle(); #2 check_output("resume_init", {24'd0, dut_v}, {24'd0, V_INIT});
    next_cycle(); #2 check_output("resume_run", {24'd0, dut_v}, {24'd0, V_ADV});

    // Asynchronous reset in the middle of a drain
    next_cycle(); halt_req = 1;
    next_cycle(); #1 rst = 1;
    #1 check_output("async_rst", {24'd0, dut_v}, {24'd0, V_INIT});
    @(posedge clk); #1 rst = 0;
    #2 check_output("rst_init", {24'd0, dut_v}, {24'd0, V_INIT});
    next_cycle(); #2 check_output("rst_run", {24'd0, dut_v}, {24'd0, V_ADV});

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      apply_stimulus();
    end
    @(posedge clk); #1 clear_in(); rst = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
